mux_arb_npu: RTL and testbench
==============================

Name: mux_arb_npu

Overview:
- Arbitrated, registered N-to-1 flit multiplexer for router output ports.
- Selects among up to N requesting inputs using round-robin or fixed MSB priority.
- Optionally locks the grant for a whole packet until the tail flit passes.
- Drives a one-stage output register with valid/ready backpressure, so upstream sees a per-input ready.

Parameters:
- N, 4, number of input channels (>=1).
- WIDTH, 32, flit data width in bits.
- ARB_MODE, "RR", "RR" = round-robin; "MSB" = fixed priority, highest index wins.
- PKT_LOCK, "TRUE", "TRUE" holds the grant from a non-tail flit until its tail flit; "FALSE" re-arbitrates every flit.
- IDX_W, (N>1 ? $clog2(N) : 1), index width (derived, not to be overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- i_valid  input  N  per-input flit valid.
- i_data  input  N x WIDTH  per-input flit data, packed [N-1:0][WIDTH-1:0].
- i_tail  input  N  per-input tail-flit marker; a single-flit packet has tail=1.
- i_ready  output  N  per-input accept. A flit transfers on input k when i_valid[k] & i_ready[k].
- o_valid  output  1  output register holds a flit.
- o_data  output  WIDTH  registered flit data.
- o_tail  output  1  registered tail marker.
- o_index  output  IDX_W  index of the input that supplied the current o_data.
- o_ready  input  1  downstream accept. The output transfers when o_valid & o_ready.

Behaviour:
- Reset (async, reset==0):
  - o_valid=0, o_data=0, o_tail=0, o_index=0.
  - lock=0, lock_owner=0, rr_ptr=0.
  - i_ready=0 while reset is held.
- load_en = !o_valid | o_ready. The output register loads only when load_en=1.
- Latency: an accepted input flit appears on o_data the next cycle. Full throughput is one flit per cycle when o_ready=1.
- Request vector: req = i_valid. If lock=1, req is masked to the single bit lock_owner.
- Arbitration (combinational, same cycle):
  - "MSB": the winner is the highest set index of req.
  - "RR": the winner is the first set bit of req scanning rr_ptr, rr_ptr+1, ..., wrapping modulo N.
  - grant_valid = |req.
- i_ready[k] = load_en & grant_valid & (winner==k). At most one bit of i_ready is set in any cycle (one-hot or zero).
- When load_en=1 and grant_valid=1:
  - Register o_data=i_data[winner], o_tail=i_tail[winner], o_index=winner, o_valid=1.
- When load_en=1 and grant_valid=0:
  - o_valid<=0. o_data, o_tail and o_index hold their previous values.
- When load_en=0: all output registers hold. No input is accepted (backpressure).
- Lock, PKT_LOCK="TRUE":
  - Accepting a flit with tail=0 sets lock=1 and lock_owner=winner.
  - Accepting a flit with tail=1 clears lock.
  - While locked and the owner's i_valid=0, no other input is granted. o_valid drops to 0 on the next load (a bubble) and lock is held.
- Lock, PKT_LOCK="FALSE": lock stays 0 permanently and i_tail is only passed through.
- rr_ptr update ("RR" only):
  - On an accepted flit that ends a grant (tail=1, or any flit when PKT_LOCK="FALSE"), rr_ptr <= (winner+1) mod N.
  - Otherwise rr_ptr holds.
- N=1: the winner is always 0 and the block degenerates to a pipelined register slice with lock tracking.
- Simultaneous output drain and new load in the same cycle is legal and gives no bubble.
- Reset asserted mid-packet clears the lock immediately. Any partially sent packet is abandoned and not resumed.

Test Plan:
- Reset then idle, N=4, o_ready=1, all i_valid=0 -> o_valid=0, o_data=0, o_index=0, i_ready=4'b0000 for 10 cycles.
- RR fairness, PKT_LOCK="FALSE", i_valid=4'b1111, single-flit packets, o_ready=1 -> o_index sequence 0,1,2,3,0,1. Exactly one i_ready bit is high each cycle. One-cycle latency from data on i_data to o_data.
- Packet lock, "RR": input 2 sends a 3-flit packet (tail on the 3rd) while input 0 is valid -> o_index=2,2,2, then 0. Input 2 deasserts valid for 1 cycle mid-packet -> one bubble (o_valid=0), input 0 is not granted, lock is held.
- MSB mode, i_valid=4'b0101 -> input 2 wins every flit. Drop i_valid[2] -> input 0 is granted the next cycle.
- Backpressure: o_valid=1 with o_ready=0 for 3 cycles -> o_data, o_tail and o_index are stable, and i_ready=0. o_ready=1 -> the drain and a new load occur in the same cycle with no bubble.
- Async reset mid-packet (after flit 1 of 3 from input 1) -> outputs and lock clear without a clock edge. After release, input 3 (valid) is granted first because rr_ptr=0 scans 0,1,2,3 and only input 3 is requesting.

Source files
------------

// File: rtl/mux_arb_npu.sv
// Arbitrated, registered N-to-1 flit multiplexer for a router output port.
// Round-robin or fixed-MSB arbitration, optional packet lock, one-stage output register.
module mux_arb_npu #(
  parameter int    N        = 4,
  parameter int    WIDTH    = 32,
  parameter string ARB_MODE = "RR",
  parameter string PKT_LOCK = "TRUE",
  parameter int    IDX_W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N-1:0]              i_valid,
  input  logic [N-1:0][WIDTH-1:0]   i_data,
  input  logic [N-1:0]              i_tail,
  output logic [N-1:0]              i_ready,
  output logic                      o_valid,
  output logic [WIDTH-1:0]          o_data,
  output logic                      o_tail,
  output logic [IDX_W-1:0]          o_index,
  input  logic                      o_ready
);

  localparam bit IS_RR    = (ARB_MODE == "RR");
  localparam bit USE_LOCK = (PKT_LOCK == "TRUE");

  logic             r_lock;
  logic [IDX_W-1:0] r_lock_owner;
  logic [IDX_W-1:0] r_rr_ptr;

  logic             w_load_en;
  logic             w_grant_valid;
  logic             w_accept;
  logic [N-1:0]     w_req;
  logic [IDX_W-1:0] w_winner;
  logic [IDX_W-1:0] w_rr_next;

  assign w_load_en = !o_valid | o_ready;
  // i_ready must stay low while reset is held, so reset gates the accept directly.
  assign w_accept  = reset & w_load_en & w_grant_valid;

  // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_req = i_valid;
    if (r_lock) begin
      w_req               = '0;
      w_req[r_lock_owner] = i_valid[r_lock_owner];
    end
  end

  // RR scans offsets from the highest down so the last hit is the nearest to r_rr_ptr.
  always_comb begin
    w_winner      = '0;
    w_grant_valid = 1'b0;
    if (IS_RR) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (w_req[IDX_W'((int'(r_rr_ptr) + k) % N)]) begin
          w_winner      = IDX_W'((int'(r_rr_ptr) + k) % N);
          w_grant_valid = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (w_req[k]) begin
          w_winner      = IDX_W'(k);
          w_grant_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    i_ready = '0;
    if (w_accept) i_ready[w_winner] = 1'b1;
  end

  assign w_rr_next = (int'(w_winner) == N - 1) ? '0 : w_winner + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_tail       <= 1'b0;
      o_index      <= '0;
      r_lock       <= 1'b0;
      r_lock_owner <= '0;
      r_rr_ptr     <= '0;
    end else if (w_accept) begin
      o_valid <= 1'b1;
      o_data  <= i_data[w_winner];
      o_tail  <= i_tail[w_winner];
      o_index <= w_winner;
      if (USE_LOCK) begin
        r_lock       <= !i_tail[w_winner];
        r_lock_owner <= w_winner;
      end
      if (IS_RR && (i_tail[w_winner] || !USE_LOCK)) r_rr_ptr <= w_rr_next;
    end else if (w_load_en) begin
      // Nothing granted: emit a bubble but keep the last data/tail/index visible.
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arb_npu.sv
// Scoreboard bench for mux_arb_npu: three configurations (RR+lock, RR no lock, MSB+lock)
// share one randomized stimulus stream and are checked against a queue-based reference model.
module tb_mux_arb_npu;

  localparam int N = 4;
  localparam int W = 32;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]        valid;
  logic [N-1:0]        tail;
  logic [N-1:0][W-1:0] data;
  logic                ordy;

  logic [N-1:0] rdy [NI];
  logic         ov  [NI];
  logic [W-1:0] od  [NI];
  logic         ot  [NI];
  logic [1:0]   oi  [NI];

  mux_arb_npu #(.N(N), .WIDTH(W), .ARB_MODE("RR"), .PKT_LOCK("TRUE")) dut_rr_lock (
    .clk(clk), .reset(rst_n), .i_valid(valid), .i_data(data), .i_tail(tail),
    .i_ready(rdy[0]), .o_valid(ov[0]), .o_data(od[0]), .o_tail(ot[0]),
    .o_index(oi[0]), .o_ready(ordy));

  mux_arb_npu #(.N(N), .WIDTH(W), .ARB_MODE("RR"), .PKT_LOCK("FALSE")) dut_rr_free (
    .clk(clk), .reset(rst_n), .i_valid(valid), .i_data(data), .i_tail(tail),
    .i_ready(rdy[1]), .o_valid(ov[1]), .o_data(od[1]), .o_tail(ot[1]),
    .o_index(oi[1]), .o_ready(ordy));

  mux_arb_npu #(.N(N), .WIDTH(W), .ARB_MODE("MSB"), .PKT_LOCK("TRUE")) dut_msb_lock (
    .clk(clk), .reset(rst_n), .i_valid(valid), .i_data(data), .i_tail(tail),
    .i_ready(rdy[2]), .o_valid(ov[2]), .o_data(od[2]), .o_tail(ot[2]),
    .o_index(oi[2]), .o_ready(ordy));

  typedef struct {
    int           idx;
    logic [W-1:0] data;
    logic         tail;
  } flit_t;

  flit_t q0[$];
  flit_t q1[$];
  flit_t q2[$];

  bit is_rr [NI] = '{1'b1, 1'b1, 1'b0};
  bit lk    [NI] = '{1'b1, 1'b0, 1'b1};

  int           m_ptr   [NI];
  int           m_owner [NI];
  bit           m_lock  [NI];
  bit           m_ov    [NI];
  logic [N-1:0] exp_rdy [NI];
  bit           exp_ov  [NI];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push(int g, flit_t f);
    case (g)
      0:       q0.push_back(f);
      1:       q1.push_back(f);
      default: q2.push_back(f);
    endcase
  endfunction

  function automatic int qsize(int g);
    case (g)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic flit_t pop(int g);
    case (g)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Winner from the arbitration rules: highest requester, or first requester from the pointer.
  function automatic int pick(int g, logic [N-1:0] req);
    if (!is_rr[g]) begin
      for (int k = N - 1; k >= 0; k--) if (req[k]) return k;
    end else begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr[g] + k) % N;
        if (req[i]) return i;
      end
    end
    return -1;
  endfunction

  function automatic void model_reset();
    for (int g = 0; g < NI; g++) begin
      m_ptr[g] = 0; m_owner[g] = 0; m_lock[g] = 1'b0; m_ov[g] = 1'b0;
      exp_rdy[g] = '0; exp_ov[g] = 1'b0;
    end
    q0.delete(); q1.delete(); q2.delete();
  endfunction

  // Predict this cycle's handshake and the state after the coming edge.
  function automatic void model_step();
    for (int g = 0; g < NI; g++) begin
      bit           load;
      logic [N-1:0] req;
      int           w;
      flit_t        f;
      load       = !m_ov[g] || ordy;
      req        = m_lock[g] ? (valid & (N'(1) << m_owner[g])) : valid;
      w          = pick(g, req);
      exp_ov[g]  = m_ov[g];
      exp_rdy[g] = '0;
      if (load) begin
        if (w >= 0) begin
          exp_rdy[g] = N'(1) << w;
          f.idx = w; f.data = data[w]; f.tail = tail[w];
          push(g, f);
          m_ov[g] = 1'b1;
          if (lk[g]) begin
            m_lock[g]  = !tail[w];
            m_owner[g] = w;
          end
          if (is_rr[g] && (tail[w] || !lk[g])) m_ptr[g] = (w + 1) % N;
        end else begin
          m_ov[g] = 1'b0;
        end
      end
    end
  endfunction

  task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] t, input bit r);
    @(posedge clk);
    #1;
    valid = v;
    tail  = t;
    ordy  = r;
    for (int k = 0; k < N; k++) data[k] = $urandom;
    model_step();
  endtask

  task automatic check_cleared(input string tag);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("%s.i%0d.o_valid", tag, g), ov[g], 0);
      check($sformatf("%s.i%0d.o_data", tag, g), od[g], 0);
      check($sformatf("%s.i%0d.o_tail", tag, g), ot[g], 0);
      check($sformatf("%s.i%0d.o_index", tag, g), oi[g], 0);
      check($sformatf("%s.i%0d.i_ready", tag, g), rdy[g], 0);
    end
  endtask

  // Asynchronous reset between clock edges, with every input requesting.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    valid = '1;
    model_reset();
    #1;
    check_cleared("async_rst");
    repeat (2) @(posedge clk);
    #1;
    valid = '0;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      check($sformatf("i%0d.o_valid", g), ov[g], exp_ov[g]);
      check($sformatf("i%0d.i_ready", g), rdy[g], exp_rdy[g]);
      if (ov[g] && ordy) begin
        check($sformatf("i%0d.expected_flit_pending", g), qsize(g) > 0, 1);
        if (qsize(g) > 0) begin
          flit_t f;
          f = pop(g);
          check($sformatf("i%0d.o_index", g), oi[g], f.idx);
          check($sformatf("i%0d.o_data", g), od[g], f.data);
          check($sformatf("i%0d.o_tail", g), ot[g], f.tail);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    valid = '1;
    tail  = '0;
    data  = '0;
    ordy  = 1'b1;
    model_reset();
    #1;
    check_cleared("por");
    #20;
    @(posedge clk);
    #1;
    valid = '0;
    rst_n = 1'b1;

    repeat (10) cycle(4'b0000, 4'b0000, 1'b1);
    repeat (6)  cycle(4'b1111, 4'b1111, 1'b1);

    cycle(4'b0101, 4'b0000, 1'b1);
    cycle(4'b0001, 4'b0000, 1'b1);
    cycle(4'b0101, 4'b0000, 1'b1);
    cycle(4'b0101, 4'b0100, 1'b1);
    cycle(4'b0001, 4'b0001, 1'b1);

    cycle(4'b0010, 4'b0010, 1'b1);
    repeat (3) cycle(4'b1000, 4'b1000, 1'b0);
    cycle(4'b1000, 4'b1000, 1'b1);
    cycle(4'b0000, 4'b0000, 1'b1);

    repeat (1500) cycle(N'($urandom), N'($urandom), $urandom_range(0, 3) != 0);

    cycle(4'b0010, 4'b0000, 1'b1);
    do_reset();
    cycle(4'b1000, 4'b1000, 1'b1);
    cycle(4'b0000, 4'b0000, 1'b1);

    repeat (500) cycle(N'($urandom), N'($urandom), $urandom_range(0, 1) != 0);

    repeat (4) cycle(4'b0000, 4'b0000, 1'b1);
    @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) check($sformatf("i%0d.drained", g), qsize(g), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
